// File: rtl/relay_sequencer.sv
// rtl/relay_sequencer.sv - fetch/decode/execute control sequencer for the relay-computer datapath
//
// Holds the instruction register and steps IDLE -> F0..F3 -> E0 -> E1 -> F0.
// Every strobe is a Moore output decoded from the state and the instruction
// register only, so an asynchronous reset drops all strobes at once.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, leaves IDLE/HALTED
//   mem_data            memory read data, latched as the instruction in F1
//   sel_reg / ld_reg    one-hot register drive / load, order A,B,C,D,M1,M2,X,Y
//   sel_PC, ld_PC, sel_INC, ld_INC, ld_INST       PC / incrementer / IR strobes
//   sel_M, mem_read, mem_write, bus_to_mem        memory strobes
//   alu_f, ld_COND      ALU function and condition-register load
//   imm_en, imm_val     sign-extended SETAB immediate onto the bus
//   inst, phase         instruction register and state index for the LEDs
//   halted, illegal     HALTED state flag, sticky undefined-opcode flag
module relay_sequencer #(
  parameter int INST_W   = 8,
  parameter int REG_N    = 8,
  parameter int AUTO_RUN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [INST_W-1:0] mem_data,
  output logic [REG_N-1:0]  sel_reg,
  output logic [REG_N-1:0]  ld_reg,
  output logic              sel_PC,
  output logic              ld_PC,
  output logic              sel_INC,
  output logic              ld_INC,
  output logic              ld_INST,
  output logic              sel_M,
  output logic              mem_read,
  output logic              mem_write,
  output logic              bus_to_mem,
  output logic [2:0]        alu_f,
  output logic              ld_COND,
  output logic              imm_en,
  output logic [INST_W-1:0] imm_val,
  output logic [INST_W-1:0] inst,
  output logic [3:0]        phase,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_E0, S_E1, S_HALTED
  } state_t;

  state_t state, state_nx;

  logic op_mov, op_set, op_alu, op_load, op_store, op_halt, op_bad;

  assign op_mov   = (inst[7:6] == 2'b00);
  assign op_set   = (inst[7:6] == 2'b01);
  assign op_alu   = (inst[7:4] == 4'b1000);
  assign op_load  = (inst[7:2] == 6'b100100);
  assign op_store = (inst[7:2] == 6'b100110);
  assign op_halt  = (inst[7:0] == 8'hAE);
  assign op_bad   = !(op_mov || op_set || op_alu || op_load || op_store || op_halt);

  assign phase = {1'b0, state};

  function automatic logic [REG_N-1:0] onehot(input logic [2:0] idx);
    logic [REG_N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      inst    <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_F1) inst <= mem_data;
      if (state == S_E0 && op_bad) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    sel_reg    = '0;
    ld_reg     = '0;
    sel_PC     = 1'b0;
    ld_PC      = 1'b0;
    sel_INC    = 1'b0;
    ld_INC     = 1'b0;
    ld_INST    = 1'b0;
    sel_M      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    bus_to_mem = 1'b0;
    alu_f      = 3'd0;
    ld_COND    = 1'b0;
    imm_en     = 1'b0;
    imm_val    = '0;
    halted     = 1'b0;

    case (state)
      S_IDLE: if (start || AUTO_RUN != 0) state_nx = S_F0;
      S_F0: begin
        sel_PC   = 1'b1;
        mem_read = 1'b1;
        state_nx = S_F1;
      end
      S_F1: begin
        sel_PC   = 1'b1;
        mem_read = 1'b1;
        ld_INST  = 1'b1;
        ld_INC   = 1'b1;
        state_nx = S_F2;
      end
      S_F2: begin
        sel_INC  = 1'b1;
        state_nx = S_F3;
      end
      S_F3: begin
        sel_INC  = 1'b1;
        ld_PC    = 1'b1;
        state_nx = S_E0;
      end
      S_E0, S_E1: begin
        if (state == S_E1)            state_nx = S_F0;
        else if (op_halt || op_bad)   state_nx = S_HALTED;
        else                          state_nx = S_E1;

        // HALT and undefined opcodes fall through with every strobe low.
        if (op_mov) begin
          // Source equal to destination leaves the bus undriven, so the load clears it.
          if (inst[5:3] != inst[2:0]) sel_reg = onehot(inst[2:0]);
          if (state == S_E1) ld_reg = onehot(inst[5:3]);
        end else if (op_set) begin
          imm_en  = 1'b1;
          imm_val = {{(INST_W-5){inst[4]}}, inst[4:0]};
          if (state == S_E1) ld_reg = onehot({2'b00, inst[5]});
        end else if (op_alu) begin
          alu_f = inst[2:0];
          if (state == S_E1) begin
            ld_COND = 1'b1;
            ld_reg  = onehot(inst[3] ? 3'd3 : 3'd0);
          end
        end else if (op_load) begin
          sel_M    = 1'b1;
          mem_read = 1'b1;
          if (state == S_E1) ld_reg = onehot({1'b0, inst[1:0]});
        end else if (op_store) begin
          sel_M      = 1'b1;
          bus_to_mem = 1'b1;
          sel_reg    = onehot({1'b0, inst[1:0]});
          if (state == S_E1) mem_write = 1'b1;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) state_nx = S_F0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
